// File: rtl/control_unit.sv
// control_unit: hardwired Moore control sequencer driving datapath strobes through fetch (T0-T2)
// and an opcode-dependent execute sequence (T3-T7), with Stop/halt handling.
module control_unit (
    input  logic        Clock,
    input  logic        Reset_n,
    input  logic [31:0] IR,
    input  logic        Stop,
    output logic        PCout,
    output logic        MDRout,
    output logic        ZLOout,
    output logic        Cout,
    output logic        Rout,
    output logic        BAout,
    output logic        PCin,
    output logic        MARin,
    output logic        MDRin,
    output logic        IRin,
    output logic        Yin,
    output logic        Zin,
    output logic        Rin,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic        Read,
    output logic        write,
    output logic        IncPC,
    output logic        Run
);
    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_ADDI = 5'b01100;
    localparam logic [4:0] OP_ANDI = 5'b01101;
    localparam logic [4:0] OP_ORI  = 5'b01110;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    // Encoding order matters: every state but T7 and HALT advances by +1.
    typedef enum logic [3:0] {
        S_RESET, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
    } state_t;

    typedef struct packed {
        logic pc_out, mdr_out, zlo_out, c_out, r_out, ba_out;
        logic pc_in, mar_in, mdr_in, ir_in, y_in, z_in, r_in;
        logic gra, grb, grc, rd, wr, inc_pc, run;
    } ctl_t;

    state_t     r_state;
    state_t     w_next;
    logic [4:0] r_op;
    logic [4:0] w_op;
    ctl_t       r_ctl;
    logic       w_alu;
    logic       w_imm;
    logic       w_mem;
    logic       w_end;
    logic       w_unused;

    function automatic ctl_t decode(input state_t s, input logic [4:0] op);
        ctl_t c;
        logic alu, imm, base, mem;
        alu  = op inside {OP_ADD, OP_SUB, OP_AND, OP_OR};
        imm  = op inside {OP_ADDI, OP_ANDI, OP_ORI};
        base = op inside {OP_LDI, OP_LD, OP_ST};
        mem  = op inside {OP_LD, OP_ST};
        c = '0;
        c.run = s != S_HALT;
        case (s)
            S_T0: begin c.pc_out = 1'b1; c.mar_in = 1'b1; end
            S_T1: begin c.rd = 1'b1; c.mdr_in = 1'b1; c.pc_in = 1'b1; c.inc_pc = 1'b1; end
            S_T2: begin c.mdr_out = 1'b1; c.ir_in = 1'b1; end
            S_T3: begin
                c.grb    = alu | imm | base;
                c.y_in   = alu | imm | base;
                c.r_out  = alu | imm;
                c.ba_out = base;
            end
            S_T4: begin c.grc = alu; c.r_out = alu; c.c_out = !alu; c.z_in = 1'b1; end
            S_T5: begin c.zlo_out = 1'b1; c.gra = !mem; c.r_in = !mem; c.mar_in = mem; end
            S_T6: begin c.rd = op == OP_LD; c.mdr_in = 1'b1; c.gra = op == OP_ST; c.r_out = op == OP_ST; end
            S_T7: begin c.mdr_out = op == OP_LD; c.gra = op == OP_LD; c.r_in = op == OP_LD; c.wr = op == OP_ST; end
            default: ;
        endcase
        return c;
    endfunction

    always_comb begin
        w_alu = r_op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI, OP_ANDI, OP_ORI, OP_LDI};
        w_mem = r_op inside {OP_LD, OP_ST};
        w_imm = w_alu | w_mem;
        w_end = (r_state == S_T3 && !w_imm && r_op != OP_HALT) || (r_state == S_T5 && !w_mem)
              || r_state == S_T7;
        w_op  = r_state == S_T2 ? IR[31:27] : r_op;
        w_next = (r_state == S_HALT || (r_state == S_T3 && r_op == OP_HALT) || (w_end && Stop)) ? S_HALT
               : w_end ? S_T0 : state_t'(r_state + 4'd1);
    end

    // Strobes are registered from the next state so they come straight off flops.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state <= S_RESET;
            r_op    <= '0;
            r_ctl   <= decode(S_RESET, 5'b00000);
        end else begin
            r_state <= w_next;
            r_op    <= w_op;
            r_ctl   <= decode(w_next, w_op);
        end
    end

    assign w_unused = &{1'b0, IR[26:0], OP_NOP};
    assign {PCout, MDRout, ZLOout, Cout, Rout, BAout, PCin, MARin, MDRin, IRin, Yin, Zin, Rin,
            Gra, Grb, Grc, Read, write, IncPC, Run} = r_ctl;
endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: directed checks of the control sequencer's per-state strobes, Stop and halt.
module tb_control_unit;
    logic        Clock = 1'b0;
    logic        Reset_n = 1'b0;
    logic        Stop = 1'b0;
    logic [31:0] IR = '0;
    logic PCout, MDRout, ZLOout, Cout, Rout, BAout, PCin, MARin, MDRin, IRin, Yin, Zin, Rin;
    logic Gra, Grb, Grc, Read, write, IncPC, Run;
    logic [19:0] obs;
    int checks = 0;
    int passed = 0;

    localparam logic [19:0] PCO  = 20'd1 << 19;
    localparam logic [19:0] MDRO = 20'd1 << 18;
    localparam logic [19:0] ZLO  = 20'd1 << 17;
    localparam logic [19:0] CO   = 20'd1 << 16;
    localparam logic [19:0] RO   = 20'd1 << 15;
    localparam logic [19:0] BAO  = 20'd1 << 14;
    localparam logic [19:0] PCI  = 20'd1 << 13;
    localparam logic [19:0] MARI = 20'd1 << 12;
    localparam logic [19:0] MDRI = 20'd1 << 11;
    localparam logic [19:0] IRI  = 20'd1 << 10;
    localparam logic [19:0] YI   = 20'd1 << 9;
    localparam logic [19:0] ZI   = 20'd1 << 8;
    localparam logic [19:0] RI   = 20'd1 << 7;
    localparam logic [19:0] GRA  = 20'd1 << 6;
    localparam logic [19:0] GRB  = 20'd1 << 5;
    localparam logic [19:0] GRC  = 20'd1 << 4;
    localparam logic [19:0] RD   = 20'd1 << 3;
    localparam logic [19:0] WR   = 20'd1 << 2;
    localparam logic [19:0] INC  = 20'd1 << 1;
    localparam logic [19:0] RUN  = 20'd1;

    localparam logic [19:0] F0  = PCO | MARI | RUN;
    localparam logic [19:0] F1  = RD | MDRI | PCI | INC | RUN;
    localparam logic [19:0] F2  = MDRO | IRI | RUN;
    localparam logic [19:0] R3  = GRB | RO | YI | RUN;
    localparam logic [19:0] B3  = GRB | BAO | YI | RUN;
    localparam logic [19:0] A4  = GRC | RO | ZI | RUN;
    localparam logic [19:0] C4  = CO | ZI | RUN;
    localparam logic [19:0] W5  = ZLO | GRA | RI | RUN;
    localparam logic [19:0] M5  = ZLO | MARI | RUN;
    localparam logic [19:0] HLT = 20'd0;

    control_unit dut (
        .Clock(Clock), .Reset_n(Reset_n), .IR(IR), .Stop(Stop),
        .PCout(PCout), .MDRout(MDRout), .ZLOout(ZLOout), .Cout(Cout), .Rout(Rout), .BAout(BAout),
        .PCin(PCin), .MARin(MARin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin), .Zin(Zin), .Rin(Rin),
        .Gra(Gra), .Grb(Grb), .Grc(Grc), .Read(Read), .write(write), .IncPC(IncPC), .Run(Run)
    );

    assign obs = {PCout, MDRout, ZLOout, Cout, Rout, BAout, PCin, MARin, MDRin, IRin, Yin, Zin, Rin,
                  Gra, Grb, Grc, Read, write, IncPC, Run};

    always #5 Clock = ~Clock;

    always @(negedge Clock) begin
        checks++;
        if (!$onehot0({PCout, MDRout, ZLOout, Cout, Rout, BAout}) || !$onehot0({Gra, Grb, Grc}))
            $display("FAIL invariant t=%0t bus=%b gr=%b", $time,
                     {PCout, MDRout, ZLOout, Cout, Rout, BAout}, {Gra, Grb, Grc});
        else
            passed++;
    end

    task automatic test_reset();
        logic [19:0] e [5];
        e = '{F0, F1, F2, R3, A4};
        IR = 32'h1800_0000;
        repeat (2) @(negedge Clock);
        checks++;
        if (obs !== RUN) $display("FAIL reset_state got=%h exp=%h", obs, RUN); else passed++;
        Reset_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge Clock);
            checks++;
            if (obs !== e[i]) $display("FAIL reset_seq[%0d] got=%h exp=%h", i, obs, e[i]); else passed++;
        end
        #2 Reset_n = 1'b0;
        #1 checks++;
        if (obs !== RUN) $display("FAIL async_reset_mid_t4 got=%h exp=%h", obs, RUN); else passed++;
        @(negedge Clock);
        checks++;
        if (obs !== RUN) $display("FAIL reset_hold got=%h exp=%h", obs, RUN); else passed++;
        Reset_n = 1'b1;
    endtask

    task automatic test_ori();
        logic [19:0] e [6];
        int inc = 0;
        e = '{F0, F1, F2, R3, C4, W5};
        IR = 32'h7119_0019;
        for (int i = 0; i < 6; i++) begin
            @(negedge Clock);
            checks++;
            if (obs !== e[i]) $display("FAIL ori[%0d] got=%h exp=%h", i, obs, e[i]); else passed++;
            inc += int'(IncPC);
        end
        checks++;
        if (inc != 1) $display("FAIL ori_incpc got=%0d exp=1", inc); else passed++;
    endtask

    task automatic test_back_to_back();
        logic [19:0] e [6];
        e = '{F0, F1, F2, R3, A4, W5};
        IR = 32'h1888_0000;
        for (int i = 0; i < 6; i++) begin
            @(negedge Clock);
            checks++;
            if (obs !== e[i]) $display("FAIL add[%0d] got=%h exp=%h", i, obs, e[i]); else passed++;
        end
        IR = 32'h2110_0000;
        for (int i = 0; i < 6; i++) begin
            @(negedge Clock);
            checks++;
            if (obs !== e[i]) $display("FAIL sub[%0d] got=%h exp=%h", i, obs, e[i]); else passed++;
            if (i == 3) begin
                checks++;
                if (dut.r_op !== 5'b00100) $display("FAIL sub_latch got=%b exp=00100", dut.r_op); else passed++;
            end
            if (i == 4) IR = 32'h0000_0000;
        end
    endtask

    task automatic test_ld_st();
        logic [19:0] e [8];
        e = '{F0, F1, F2, B3, C4, M5, RD | MDRI | RUN, MDRO | GRA | RI | RUN};
        IR = 32'h0108_0010;
        for (int i = 0; i < 8; i++) begin
            @(negedge Clock);
            checks++;
            if (obs !== e[i]) $display("FAIL ld[%0d] got=%h exp=%h", i, obs, e[i]); else passed++;
        end
        e = '{F0, F1, F2, B3, C4, M5, GRA | RO | MDRI | RUN, WR | RUN};
        IR = 32'h1108_0020;
        for (int i = 0; i < 8; i++) begin
            @(negedge Clock);
            checks++;
            if (obs !== e[i]) $display("FAIL st[%0d] got=%h exp=%h", i, obs, e[i]); else passed++;
        end
    endtask

    task automatic test_illegal();
        logic [19:0] e [5];
        e = '{F0, F1, F2, RUN, F0};
        IR = 32'hF800_0000;
        for (int i = 0; i < 5; i++) begin
            @(negedge Clock);
            checks++;
            if (obs !== e[i]) $display("FAIL illegal[%0d] got=%h exp=%h", i, obs, e[i]); else passed++;
        end
        e = '{F1, F2, R3, C4, W5};
        IR = 32'h6000_0005;
        for (int i = 0; i < 5; i++) begin
            @(negedge Clock);
            checks++;
            if (obs !== e[i]) $display("FAIL after_illegal[%0d] got=%h exp=%h", i, obs, e[i]); else passed++;
        end
    endtask

    task automatic test_stop();
        logic [19:0] e [6];
        e = '{F0, F1, F2, R3, C4, W5};
        IR = 32'h6108_0007;
        for (int i = 0; i < 6; i++) begin
            @(negedge Clock);
            checks++;
            if (obs !== e[i]) $display("FAIL stop_addi[%0d] got=%h exp=%h", i, obs, e[i]); else passed++;
            if (i == 2 || i == 4) Stop = 1'b1;
            if (i == 3) Stop = 1'b0;
        end
        repeat (3) begin
            @(negedge Clock);
            checks++;
            if (obs !== HLT) $display("FAIL stop_halt got=%h exp=%h", obs, HLT); else passed++;
        end
        Stop = 1'b0;
        repeat (2) begin
            @(negedge Clock);
            checks++;
            if (obs !== HLT) $display("FAIL stop_no_resume got=%h exp=%h", obs, HLT); else passed++;
        end
    endtask

    task automatic test_halt();
        logic [19:0] e [4];
        e = '{F0, F1, F2, RUN};
        for (int v = 0; v < 2; v++) begin
            Reset_n = 1'b0;
            Stop = v[0];
            @(negedge Clock);
            Reset_n = 1'b1;
            IR = 32'hD800_0000;
            for (int i = 0; i < 4; i++) begin
                @(negedge Clock);
                checks++;
                if (obs !== e[i]) $display("FAIL halt%0d[%0d] got=%h exp=%h", v, i, obs, e[i]); else passed++;
            end
            repeat (20) begin
                @(negedge Clock);
                checks++;
                if (obs !== HLT) $display("FAIL halt%0d_hold got=%h exp=%h", v, obs, HLT); else passed++;
            end
            Stop = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_ori();
        test_back_to_back();
        test_ld_st();
        test_illegal();
        test_stop();
        test_halt();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/control_unit.md
# control_unit

Hardwired Moore-style control sequencer for the datapath. It steps through instruction fetch (T0–T2) and then an opcode-dependent execute sequence, decoding the opcode from the IR. Each cycle it drives the datapath's register-enable, bus-select, register-select and memory strobes. It sits directly upstream of the datapath and replaces hand-driven per-state control stimulus.

## Interface

Parameters: none. Opcode encodings are fixed localparams: ld 00000, ldi 00001, st 00010, add 00011, sub 00100, and 00101, or 00110, addi 01100, andi 01101, ori 01110, nop 11010, halt 11011.

Ports:
- Clock  in  1  system clock, rising-edge active
- Reset_n  in  1  asynchronous, active-low reset
- IR  in  32  instruction register contents; opcode = IR[31:27]
- Stop  in  1  level request to halt at the next instruction boundary
- PCout, MDRout, ZLOout, Cout, Rout, BAout  out  1 each  bus source selects
- PCin, MARin, MDRin, IRin, Yin, Zin, Rin  out  1 each  register load enables
- Gra, Grb, Grc  out  1 each  register-field selects (one-hot or all 0)
- Read, write, IncPC  out  1 each  memory read, memory write, PC increment
- Run  out  1  1 while executing; 0 when halted

## Operation

- States: RESET, T0–T7, HALT. One state per clock. Outputs are a pure function of the state and the latched opcode, with no glitch-producing paths from IR.
- The opcode is latched into an internal 5-bit register on the T2→T3 edge. Execute states use only the latched value.
- Fetch, common to all instructions:
  - T0: PCout, MARin.
  - T1: Read, MDRin, PCin, IncPC.
  - T2: MDRout, IRin.
- Execute, add/sub/and/or:
  - T3: Grb, Rout, Yin.
  - T4: Grc, Rout, Zin.
  - T5: ZLOout, Gra, Rin, then → T0.
- Execute, addi/andi/ori:
  - T3: Grb, Rout, Yin.
  - T4: Cout, Zin.
  - T5: ZLOout, Gra, Rin, then → T0.
- Execute, ldi:
  - T3: Grb, BAout, Yin.
  - T4: Cout, Zin.
  - T5: ZLOout, Gra, Rin, then → T0.
- Execute, ld:
  - T3: Grb, BAout, Yin.
  - T4: Cout, Zin.
  - T5: ZLOout, MARin.
  - T6: Read, MDRin.
  - T7: MDRout, Gra, Rin, then → T0.
- Execute, st:
  - T3: Grb, BAout, Yin.
  - T4: Cout, Zin.
  - T5: ZLOout, MARin.
  - T6: Gra, Rout, MDRin (Read=0).
  - T7: write, then → T0.
- nop and any unlisted opcode: T3 with all outputs 0, then → T0.
- halt: T3 → HALT.
- Stop: sampled only at instruction end (the final execute state). If Stop=1, the next state is HALT instead of T0.
- HALT: all strobes 0, Run=0. Remains in HALT until Reset_n is asserted; Stop deassertion does not resume.
- Invariant: at most one bus source (PCout, MDRout, ZLOout, Cout, Rout, BAout) high in any state. At most one of Gra/Grb/Grc high.

## Timing

- Reset_n=0 forces RESET immediately, asynchronously, including mid-instruction. In RESET all outputs are 0 except Run=1, and the latched opcode is cleared to 00000.
- First rising edge with Reset_n=1: RESET → T0.
- Instruction latency, from T0 entry to the next T0 entry:
  - ALU register, immediate, and ldi: 6 cycles.
  - ld and st: 8 cycles.
  - nop: 4 cycles.
- IR must be stable from the end of T2 through the T2→T3 edge. IR changes after that edge do not affect the executing instruction.
- Outputs change only after rising edges, or asynchronously on reset. Each strobe is high for exactly one full cycle per state entered.
- Stop asserted and deasserted between instruction-end states is ignored.
- Stop=1 simultaneously with a halt opcode: result is HALT, identical to either alone.
- Reset released while Stop=1: enters T0 normally. Stop is next evaluated at the end of the first instruction.

## Test plan

- Reset, then check the state sequence: Reset_n pulsed low mid-T4 → all strobes 0 and Run=1 within the same cycle. After release, T0 shows PCout=MARin=1 on the first edge.
- ori: IR=32'h7119_0019 (ori R2,R3,$25, opcode 01110) → T3: Grb/Rout/Yin, T4: Cout/Zin, T5: ZLOout/Gra/Rin, then T0. Total 6 cycles, PC incremented once (IncPC high exactly 1 cycle).
- add then sub back-to-back: T4 shows Grc/Rout/Zin for each. The opcode latched at T2→T3 of the second instruction is 00100, and changing IR during T4 has no effect.
- ld and st: ld → T6 Read/MDRin, T7 MDRout/Gra/Rin. st → T6 Gra/Rout/MDRin with Read=0, T7 write=1 for one cycle. Each 8 cycles.
- halt and Stop: halt opcode → HALT after T3, Run=0 held for ≥20 cycles. Separately, Stop=1 during an addi's T3 (ignored) and T5 (taken) → HALT after T5, with no T0 following.
- Illegal opcode 11111: acts as nop (T3 with all strobes 0), returns to T0 after 4 cycles. The bus-source one-hot invariant is asserted every cycle of every test.
